// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle control unit for the ARM-subset processor.
// Sequences fetch/decode/execute/memory/write-back, owns the NZCV flags and
// produces every datapath select and write enable.
// Optional feature macro: COND_EXEC_EN (condition check gating writes).
// With COND_EXEC_EN undefined every instruction executes (cond_ex_q tied 1)
// while the flag registers are still updated for debug observability.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned CMD_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    state_t              state_q;
    state_t              state_d;
    logic [FLAG_W-1:0]   flags_q;
    logic                cond_ex_q;

    logic [CMD_W-1:0]    cmd;
    logic                i_bit;
    logic                s_bit;
    logic                is_cmp;
    logic                cmd_legal;
    logic                cv_cmd;
    logic [1:0]          alu_dec;

    logic                fetch_pc;
    logic                ir_write;
    logic                regw;
    logic                memw;
    logic                branch;
    logic                pcs;
    logic                in_exec;
    logic                flag_we;

    assign cmd   = Funct[4:1];
    assign i_bit = Funct[5];
    assign s_bit = Funct[0];

    // Data-processing command decode: ALU op, legality and which flags it owns
    always_comb begin
        alu_dec   = 2'b00;
        cmd_legal = 1'b1;
        cv_cmd    = 1'b0;
        is_cmp    = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_dec = 2'b00; cv_cmd = 1'b1; end
            CMD_SUB: begin alu_dec = 2'b01; cv_cmd = 1'b1; end
            CMD_AND: alu_dec = 2'b10;
            CMD_ORR: alu_dec = 2'b11;
            CMD_CMP: begin alu_dec = 2'b01; cv_cmd = 1'b1; is_cmp = 1'b1; end
            default: cmd_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore selects; regw/memw/branch are unqualified intents
    always_comb begin
        state_d     = state_q;
        fetch_pc    = 1'b0;
        ir_write    = 1'b0;
        regw        = 1'b0;
        memw        = 1'b0;
        branch      = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUControl  = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                fetch_pc  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                memw    = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = cmd_legal ? alu_dec : 2'b00;
                state_d    = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = cmd_legal ? alu_dec : 2'b00;
                state_d    = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                regw      = cmd_legal & ~is_cmp;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate and register-address selects follow the opcode in every state
    assign ImmSrc = Op;
    assign RegSrc = {Op == OP_MEM, Op == OP_BR};

    // PC-source decision; regw and branch are only raised in write-back states
    assign pcs = branch | (regw & (Rd == 4'hF));

    // Qualified write enables, held low for the whole time reset is asserted
    always_comb begin
        PCWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        IRWrite  = 1'b0;
        if (reset_n) begin
            PCWrite  = fetch_pc | (pcs & cond_ex_q);
            MemWrite = memw & cond_ex_q;
            RegWrite = regw & cond_ex_q;
            IRWrite  = ir_write;
        end
    end

    assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign flag_we = in_exec & cmd_legal & (s_bit | is_cmp) & cond_ex_q;

    // Flag registers: NZ for every legal command, CV only for arithmetic ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (flag_we) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (cv_cmd) begin
                flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

`ifdef COND_EXEC_EN
    logic cond_ok;
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // ARM condition evaluation against the current flag registers
    always_comb begin
        cond_ok = 1'b0;
        case (Cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = ~flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = ~flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = ~flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = ~flag_v;
            4'b1000: cond_ok = flag_c & ~flag_z;
            4'b1001: cond_ok = ~flag_c | flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ok = flag_z | (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Condition result is captured once, on the edge leaving DECODE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_ex_q <= 1'b0;
        end else if (state_q == S_DECODE) begin
            cond_ex_q <= cond_ok;
        end
    end
`else
    logic unused_cond_dbg;

    // Every instruction executes; flags and Cond stay around only as debug state
    assign cond_ex_q       = 1'b1;
    assign unused_cond_dbg = &{1'b0, Cond, flags_q};
`endif

endmodule
